// File: rtl/mem_access_controller.sv
// Sequences 32-bit MEM-stage accesses onto a 16-bit SRAM as two half-word phases.
module mem_access_controller #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned SRAM_ADDR_W = 18
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic                   sram_we_n,
    output logic [15:0]            sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [15:0]            sram_dq_in
);

    localparam int unsigned WORD_W   = SRAM_ADDR_W - 1;
    localparam logic [2:0]  WAIT_CNT = 3'(WAIT_CYCLES);
    localparam logic [31:0] BASE     = 32'(ADDR_BASE);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_t;

    state_t                   state,     state_n;
    logic [2:0]               cnt,       cnt_n;
    logic                     op_wr,     op_wr_n;
    logic [WORD_W-1:0]        word_q,    word_n;
    logic [31:0]              wdata_q,   wdata_n;
    logic [31:0]              rdata_n;
    logic [SRAM_ADDR_W-1:0]   sram_addr_n;
    logic                     sram_we_n_n;
    logic                     sram_dq_oe_n;
    logic [15:0]              sram_dq_out_n;
    logic [WORD_W-1:0]        word_in;

    // Word index of the incoming request; wraps modulo the SRAM size.
    assign word_in = WORD_W'((addr - BASE) >> 2);

    // Pipeline may advance when idle with no request, or in the completion cycle.
    assign ready = ((state == IDLE) && !rd_en && !wr_en) || (state == DONE);

    // State, latches, read data and SRAM pins; all cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            op_wr       <= 1'b0;
            word_q      <= '0;
            wdata_q     <= 32'd0;
            rdata       <= 32'd0;
            sram_addr   <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_dq_out <= 16'd0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            op_wr       <= op_wr_n;
            word_q      <= word_n;
            wdata_q     <= wdata_n;
            rdata       <= rdata_n;
            sram_addr   <= sram_addr_n;
            sram_we_n   <= sram_we_n_n;
            sram_dq_oe  <= sram_dq_oe_n;
            sram_dq_out <= sram_dq_out_n;
        end
    end

    // Next-state, latch, capture and SRAM pin decode for the coming cycle.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        op_wr_n       = op_wr;
        word_n        = word_q;
        wdata_n       = wdata_q;
        rdata_n       = rdata;
        sram_addr_n   = sram_addr;
        sram_we_n_n   = 1'b1;
        sram_dq_oe_n  = 1'b0;
        sram_dq_out_n = 16'd0;

        case (state)
            IDLE: begin
                if (wr_en || rd_en) begin
                    op_wr_n = wr_en;
                    word_n  = word_in;
                    wdata_n = wdata;
                    cnt_n   = 3'd0;
                    state_n = LOW;
                end
            end
            LOW: begin
                if (cnt == WAIT_CNT) begin
                    cnt_n   = 3'd0;
                    state_n = HIGH;
                    if (!op_wr) begin
                        rdata_n[15:0] = sram_dq_in;
                    end
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            HIGH: begin
                if (cnt == WAIT_CNT) begin
                    cnt_n   = 3'd0;
                    state_n = DONE;
                    if (!op_wr) begin
                        rdata_n[31:16] = sram_dq_in;
                    end
                end else begin
                    cnt_n = cnt + 3'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Pins are registered, so decode them from the state being entered.
        if (state_n == LOW) begin
            sram_addr_n = {word_n, 1'b0};
            if (op_wr_n) begin
                sram_we_n_n   = 1'b0;
                sram_dq_oe_n  = 1'b1;
                sram_dq_out_n = wdata_n[15:0];
            end
        end else if (state_n == HIGH) begin
            sram_addr_n = {word_n, 1'b1};
            if (op_wr_n) begin
                sram_we_n_n   = 1'b0;
                sram_dq_oe_n  = 1'b1;
                sram_dq_out_n = wdata_n[31:16];
            end
        end
    end

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller: vector table plus reset and back-to-back sequences.
module tb_mem_access_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n, sram_dq_oe;
    logic [15:0] sram_dq_out, sram_dq_in;

    logic        rd0;
    logic [31:0] addr0;
    logic        wr0   = 1'b0;
    logic [31:0] wdata0 = 32'd0;
    logic [31:0] rdata0;
    logic        ready0;
    logic [17:0] sram_addr0;
    logic        sram_we_n0, sram_dq_oe0;
    logic [15:0] sram_dq_out0, sram_dq_in0;

    logic [15:0] mem [16];
    logic        mem_load;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    mem_access_controller #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .sram_addr(sram_addr), .sram_we_n(sram_we_n),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in)
    );

    mem_access_controller #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .rd_en(rd0), .wr_en(wr0),
        .addr(addr0), .wdata(wdata0), .rdata(rdata0), .ready(ready0),
        .sram_addr(sram_addr0), .sram_we_n(sram_we_n0),
        .sram_dq_out(sram_dq_out0), .sram_dq_oe(sram_dq_oe0),
        .sram_dq_in(sram_dq_in0)
    );

    // Small SRAM model for the main instance: preload, then write while we_n is low.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
            mem[2] <= 16'h5678;
            mem[3] <= 16'h1234;
        end else if (!sram_we_n) begin
            mem[sram_addr[3:0]] <= sram_dq_out;
        end
    end
    assign sram_dq_in = mem[sram_addr[3:0]];

    // Read-only SRAM contents for the zero-wait instance.
    always_comb begin
        case (sram_addr0)
            18'd0:   sram_dq_in0 = 16'hAAAA;
            18'd1:   sram_dq_in0 = 16'hBBBB;
            18'd2:   sram_dq_in0 = 16'h5678;
            18'd3:   sram_dq_in0 = 16'h1234;
            default: sram_dq_in0 = 16'h0000;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    typedef struct {
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] ha;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs [8];
    logic [17:0] last_ha;

    // One access on the WAIT_CYCLES=1 instance; checks every cycle of the 6-cycle window.
    task automatic run_vec(input int idx, input vec_t v);
        logic        e_rdy, e_we_n, e_oe;
        logic [17:0] e_addr;
        logic [15:0] e_dq;
        @(negedge clk);
        rd_en = v.rd; wr_en = v.wr; addr = v.addr; wdata = v.wdata;
        #1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            e_rdy = (k == 5); e_we_n = 1'b1; e_oe = 1'b0; e_dq = 16'h0000;
            if (k == 0)      e_addr = last_ha;
            else if (k <= 2) e_addr = v.ha;
            else             e_addr = v.ha + 18'd1;
            if (k >= 1 && k <= 4 && v.wr) begin
                e_we_n = 1'b0; e_oe = 1'b1;
                e_dq   = (k <= 2) ? v.wdata[15:0] : v.wdata[31:16];
            end
            chk($sformatf("vec%0d_cyc%0d", idx, k),
                64'({ready, sram_addr, sram_we_n, sram_dq_oe, sram_dq_out}),
                64'({e_rdy, e_addr, e_we_n, e_oe, e_dq}));
            if (k == 5) begin
                chk($sformatf("vec%0d_rdata", idx), 64'(rdata), 64'(v.exp_rdata));
                rd_en = 1'b0; wr_en = 1'b0;
            end
        end
        last_ha = v.ha + 18'd1;
    endtask

    initial begin
        //        wr    rd    addr          wdata          ha         rdata
        vecs[0] = '{1'b1, 1'b0, 32'd1024,     32'hDEADBEEF, 18'h00000, 32'h00000000};
        vecs[1] = '{1'b0, 1'b1, 32'd1028,     32'h00000000, 18'h00002, 32'h12345678};
        vecs[2] = '{1'b0, 1'b1, 32'd1024,     32'h00000000, 18'h00000, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b1, 32'd1032,     32'hCAFEF00D, 18'h00004, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b1, 32'd1032,     32'h00000000, 18'h00004, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 1'b0, 32'h00080400, 32'h0BADC0DE, 18'h00000, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 1'b1, 32'd1024,     32'h00000000, 18'h00000, 32'h0BADC0DE};
        vecs[7] = '{1'b0, 1'b1, 32'd1020,     32'h00000000, 18'h3FFFE, 32'h00000000};

        rst = 1'b0; mem_load = 1'b1;
        rd_en = 1'b0; wr_en = 1'b0; addr = 32'd0; wdata = 32'd0;
        rd0 = 1'b0; addr0 = 32'd0;
        last_ha = 18'd0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_ready", 64'(ready), 64'(1'b1));
        chk("rst_we_n", 64'(sram_we_n), 64'(1'b1));
        chk("rst_oe", 64'(sram_dq_oe), 64'(1'b0));
        chk("rst_rdata", 64'(rdata), 64'(32'd0));
        chk("rst_addr_dq", 64'({sram_addr, sram_dq_out}), 64'({18'd0, 16'd0}));
        rd_en = 1'b1; #1;
        chk("rst_ready_req", 64'(ready), 64'(1'b0));
        rd_en = 1'b0; #1;
        @(negedge clk);
        rst = 1'b1; mem_load = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(ready), 64'(1'b1));

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset asserted during the HIGH phase of a write.
        @(negedge clk);
        wr_en = 1'b1; addr = 32'd1036; wdata = 32'h11112222;
        repeat (3) @(negedge clk);
        chk("mid_high_pins", 64'({sram_we_n, sram_dq_oe, sram_dq_out, sram_addr}),
            64'({1'b0, 1'b1, 16'h1111, 18'd7}));
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_pins", 64'({sram_we_n, sram_dq_oe, sram_dq_out, sram_addr}),
            64'({1'b1, 1'b0, 16'h0000, 18'd0}));
        chk("mid_rst_rdata", 64'(rdata), 64'(32'd0));
        chk("mid_rst_ready_req", 64'(ready), 64'(1'b0));
        wr_en = 1'b0; #1;
        chk("mid_rst_ready_noreq", 64'(ready), 64'(1'b1));
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("after_rst_idle", 64'({ready, sram_we_n, sram_dq_oe}), 64'({1'b1, 1'b1, 1'b0}));
        rd_en = 1'b1; #1;
        chk("after_rst_ready_req", 64'(ready), 64'(1'b0));
        rd_en = 1'b0; #1;
        chk("after_rst_ready_noreq", 64'(ready), 64'(1'b1));

        // Back-to-back reads on the zero-wait instance.
        @(negedge clk);
        rd0 = 1'b1; addr0 = 32'd1028;
        #1;
        for (int k = 0; k < 8; k++) begin
            logic [17:0] e_a;
            if (k > 0) @(negedge clk);
            case (k)
                0:       e_a = 18'd0;
                1:       e_a = 18'd2;
                2, 3, 4: e_a = 18'd3;
                5:       e_a = 18'd0;
                default: e_a = 18'd1;
            endcase
            chk($sformatf("b2b_cyc%0d", k),
                64'({ready0, sram_addr0, sram_we_n0, sram_dq_oe0, sram_dq_out0}),
                64'({(k == 3 || k == 7), e_a, 1'b1, 1'b0, 16'h0000}));
            if (k == 3) begin
                chk("b2b_rdata1", 64'(rdata0), 64'(32'h12345678));
                addr0 = 32'd1024;
            end
            if (k == 7) begin
                chk("b2b_rdata2", 64'(rdata0), 64'(32'hBBBBAAAA));
                rd0 = 1'b0;
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_access_controller.md
# mem_access_controller

Sequences data-memory accesses issued by the MEM stage onto a 16-bit external SRAM. A 32-bit word access is split into two half-word phases (low, then high), each stretched by a programmable wait count. The block drives `ready` low for the duration of an access; the pipeline uses `~ready` as its `freeze` input, so every stage register holds until the access completes.

## Interface
Parameters:
- `WAIT_CYCLES`, default 1: extra cycles each half-word phase is held on the SRAM bus (phase length = WAIT_CYCLES+1); legal range 0..7.
- `ADDR_BASE`, default 1024: byte address subtracted from `addr` before mapping to SRAM.
- `SRAM_ADDR_W`, default 18: SRAM half-word address width.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rd_en`  in  1  word read request from MEM stage.
- `wr_en`  in  1  word write request from MEM stage.
- `addr`  in  32  byte address of the access, word aligned.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, registered.
- `ready`  out  1  high when the pipeline may advance.
- `sram_addr`  out  SRAM_ADDR_W  SRAM half-word address.
- `sram_we_n`  out  1  SRAM write strobe, active low.
- `sram_dq_out`  out  16  data driven toward the SRAM.
- `sram_dq_oe`  out  1  tri-state enable for `sram_dq_out` (tri-state buffer lives at top level).
- `sram_dq_in`  in  16  data returned by the SRAM.

## Operation
- States: IDLE, LOW, HIGH, DONE. Wait counter width 3 bits.
- IDLE: if `wr_en` or `rd_en`, latch `addr`, `wdata`, and the op (write if `wr_en`; **`wr_en` has priority**, so simultaneous `rd_en` is ignored). Clear the counter and go to LOW.
- Word index `w = (addr - ADDR_BASE) >> 2`, truncated to SRAM_ADDR_W-1 bits; it wraps modulo the SRAM size with no range check. LOW drives `sram_addr = {w,0}` and HIGH drives `{w,1}`.
- LOW and HIGH: counter increments each cycle. When the counter equals WAIT_CYCLES, clear the counter and advance LOW→HIGH or HIGH→DONE.
- Write op, in LOW and HIGH:
  - `sram_we_n=0`, `sram_dq_oe=1`.
  - `sram_dq_out` = `wdata[15:0]` in LOW, `wdata[31:16]` in HIGH.
- Read op: `sram_we_n=1`, `sram_dq_oe=0`. On the final cycle of LOW, capture `sram_dq_in` into `rdata[15:0]`; on the final cycle of HIGH, capture it into `rdata[31:16]`.
- DONE: one cycle, then unconditionally return to IDLE. A request still asserted in that IDLE cycle starts a new access.
- `ready = (state==IDLE && !rd_en && !wr_en) || state==DONE` (combinational).
- All SRAM outputs are decoded from registered state and latched registers only; there is no combinational path from `addr`, `wdata` or `wr_en` to them.
- Outside LOW/HIGH: `sram_we_n=1`, `sram_dq_oe=0`, `sram_dq_out=0`, `sram_addr` holds its last value.
- `rdata` holds between reads; writes never modify it.

## Timing
- On `rst` low, asynchronously:
  - state → IDLE, counter → 0, latches → 0, `rdata` → 0;
  - `sram_addr` → 0, `sram_we_n` → 1, `sram_dq_oe` → 0, `sram_dq_out` → 0;
  - `ready` = `!(rd_en|wr_en)`.
- Reset mid-access aborts immediately. No SRAM strobe persists past reset assertion, and no partial `rdata` update occurs after it.
- Access latency:
  - `ready` is low for 2·WAIT_CYCLES+3 cycles, starting in the cycle the request is first seen in IDLE; then it is high for exactly one cycle (DONE).
  - With WAIT_CYCLES=1: 5 low cycles, then ready in cycle 6.
  - With WAIT_CYCLES=0: 3 low cycles.
- `rdata` is valid in the DONE cycle, i.e. the cycle the pipeline register samples it.
- The requester must hold `rd_en`/`wr_en`/`addr`/`wdata` stable while `ready`=0. Changes after IDLE latching are ignored.
- Back-to-back requests: the next access begins the cycle after DONE. There is no idle bubble beyond DONE.

## Test plan
- Reset with `rd_en`=0 and `wr_en`=0 → `ready`=1, `sram_we_n`=1, `sram_dq_oe`=0, `rdata`=0.
- WAIT_CYCLES=1, write `addr`=1024, `wdata`=0xDEADBEEF:
  - `ready` low 5 cycles;
  - SRAM address 0 with data 0xBEEF and `we_n`=0 for 2 cycles;
  - then address 1 with data 0xDEAD for 2 cycles;
  - DONE, then `ready`=1.
- Read `addr`=1028, with the SRAM model holding half-words 2=0x5678 and 3=0x1234 → `rdata`=0x12345678 in the DONE cycle; `sram_dq_oe`=0 throughout.
- Assert `rd_en` and `wr_en` together → a write is performed and `rdata` is unchanged.
- Assert `rst` low during the HIGH phase of a write → `sram_we_n`=1 and `oe`=0 immediately; after release, state is IDLE and `ready` follows the request inputs.
- Two back-to-back reads with WAIT_CYCLES=0:
  - `ready` pattern 0,0,0,1,0,0,0,1;
  - the second read's `sram_addr` sequence starts in the cycle after the first DONE.
